shifter_operand_unit: RTL and testbench
=======================================

// Module: shifter_operand_unit
// PURPOSE
//  Iterative ARM shifter-operand stage, directly upstream of the ALU. Shifts register RM
//  per ARM LSL/LSR/ASR/ROR/RRX rules (immediate or register amount) one bit per cycle.
//  Delivers the ALU B operand (B_OUT) and shifter carry-out (SH_C); SH_C feeds the
//  C flag of logical ops. Start/done handshake toward the datapath control unit.
// PARAMETERS
//  WIDTH    32  operand width; only 32 supported (ARM semantics)
//  AMT_W    8   shift-amount width; register form uses RS[7:0]
//  CNT_W    6   iteration counter width; holds the maximum count of 33
// PORTS
//  CLK       in   1      rising-edge clock
//  RESET_N   in   1      asynchronous, active-low reset
//  START     in   1      request; sampled only in IDLE
//  REG_SHIFT in   1      1 = register amount SH_AMT[7:0]; 0 = immediate amount SH_AMT[4:0]
//  SH_TYPE   in   2      00 LSL, 01 LSR, 10 ASR, 11 ROR
//  SH_AMT    in   AMT_W  shift amount
//  RM        in   WIDTH  operand to shift
//  CIN       in   1      current C flag
//  B_OUT     out  WIDTH  shifted operand to ALU B input
//  SH_C      out  1      shifter carry-out
//  BUSY      out  1      high while in SHIFT
//  DONE      out  1      one-cycle pulse when B_OUT/SH_C are valid
// BEHAVIOUR
//  Reset: B_OUT=0, SH_C=0, BUSY=0, DONE=0, state IDLE, counter 0. Asynchronous.
//    Reset mid-shift aborts the operation; no DONE is produced.
//  States: IDLE -> (START) SHIFT -> (count==0) FIN -> IDLE.
//    FIN drives DONE=1 for exactly one cycle.
//  At START, RM and CIN are latched into a working register and carry. Count N and the
//    special case are decoded once from SH_TYPE, SH_AMT and REG_SHIFT:
//   imm LSL#0 / reg amt==0 (any type): N=0; B=RM; C=CIN.
//   imm LSR#0, ASR#0: treated as #32.
//   imm ROR#0: RRX; N=1; one step gives {CIN,RM[31:1]} and C=RM[0].
//   reg LSL/LSR amt>32: N=33; result 0, C=0.
//   reg LSL/LSR amt==32: result 0; C=RM[0] (LSL) or RM[31] (LSR).
//   reg ASR amt>=32: N=32; result all RM[31], C=RM[31].
//   reg ROR: N=amt[4:0]. If amt[4:0]==0 and amt!=0: N=0, B=RM, C=RM[31].
//  SHIFT step: shift or rotate by 1 bit; C takes the bit shifted out; counter decrements.
//    ASR replicates bit 31. ROR feeds bit 0 into bit 31.
//  Latency: START sampled at edge k -> DONE high after edge k+N+1. N=0 gives 1 cycle;
//    worst case 34.
//  B_OUT and SH_C update only on entry to FIN, then hold until the next FIN or reset.
//  START while BUSY or in FIN: ignored, not queued. START in the cycle after DONE: accepted.
//  Inputs may change after START; only the latched values are used.
// CONFIGURATION
//  SHIFTER_BARREL_EN defined: single-cycle barrel shifter with identical results and
//    carries. START at edge k -> DONE after edge k+1 for every N; BUSY stays 0; SHIFT state
//    and counter are removed.
//  SHIFTER_BARREL_EN undefined: the iterative behaviour above.
// TESTING
//  1 imm LSL#4, RM=0x12344567, CIN=0 -> B_OUT=0x23445670, SH_C=1, DONE at k+5.
//  2 imm LSR#0, RM=0xF000FE18 -> B_OUT=0x00000000, SH_C=1, DONE at k+33;
//    reg LSL 33, RM=0x50000000 -> B_OUT=0, SH_C=0.
//  3 reg ASR 40, RM=0xB0000000 -> B_OUT=0xFFFFFFFF, SH_C=1, DONE at k+33;
//    reg ROR 32, RM=0x80000001 -> B_OUT=0x80000001, SH_C=1, DONE at k+1.
//  4 imm ROR#0 (RRX), RM=0x00000001, CIN=1 -> B_OUT=0x80000000, SH_C=1, DONE at k+2.
//  5 reg amt 0, RM=0x0DAE2310, CIN=1 -> B_OUT unchanged, SH_C=1, DONE at k+1;
//    second START while BUSY is ignored: one DONE only, first result kept.
//  6 RESET_N low at k+3 of reg LSR 16 -> all outputs 0 at once, no DONE;
//    after release, imm LSL#1 on 0x00000003 -> B_OUT=0x00000006, SH_C=0.
//  Bench runs all six in both SHIFTER_BARREL_EN builds; results must match, latency per
//    build. Random RM/amount/type sweep checked against a behavioural ARM shift model.

Source files
------------

// File: rtl/shifter_operand_unit_if.sv
// Operand/handshake bundle between the datapath control unit (master) and the
// ARM shifter-operand stage (slave).
interface shifter_operand_unit_if #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 8
);
    logic             START;
    logic             REG_SHIFT;
    logic [1:0]       SH_TYPE;
    logic [AMT_W-1:0] SH_AMT;
    logic [WIDTH-1:0] RM;
    logic             CIN;
    logic [WIDTH-1:0] B_OUT;
    logic             SH_C;
    logic             BUSY;
    logic             DONE;

    modport master (
        output START, REG_SHIFT, SH_TYPE, SH_AMT, RM, CIN,
        input  B_OUT, SH_C, BUSY, DONE
    );

    modport slave (
        input  START, REG_SHIFT, SH_TYPE, SH_AMT, RM, CIN,
        output B_OUT, SH_C, BUSY, DONE
    );
endinterface

// File: rtl/shifter_operand_unit.sv
// ARM shifter-operand stage feeding the ALU B input and the shifter carry-out.
// Default build shifts one bit per cycle (IDLE -> SHIFT -> FIN -> IDLE).
// Defining SHIFTER_BARREL_EN replaces the iterative shifter with a single-cycle
// barrel shifter (IDLE -> EVAL -> FIN -> IDLE); results and carries are identical.
module shifter_operand_unit #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 8,
    parameter int CNT_W = 6
) (
    input logic                  CLK,
    input logic                  RESET_N,
    shifter_operand_unit_if.slave bus
);
    localparam logic [1:0] T_LSL = 2'b00;
    localparam logic [1:0] T_LSR = 2'b01;
    localparam logic [1:0] T_ASR = 2'b10;

    localparam logic [1:0] S_IDLE = 2'd0;
`ifdef SHIFTER_BARREL_EN
    localparam logic [1:0] S_EVAL = 2'd1;
`else
    localparam logic [1:0] S_SHIFT = 2'd1;
`endif
    localparam logic [1:0] S_FIN = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] b_out_r;
    logic             sh_c_r;

    logic [AMT_W-1:0] amt;
    logic [CNT_W-1:0] dec_cnt;
    logic             dec_rrx;
    logic             dec_c;

    assign amt = bus.SH_AMT;

    // Decode step count, RRX mode and initial carry from the requested shift
    always_comb begin
        dec_cnt = '0;
        dec_rrx = 1'b0;
        dec_c   = bus.CIN;
        if (!bus.REG_SHIFT) begin
            case (bus.SH_TYPE)
                T_LSL: dec_cnt = CNT_W'(amt[4:0]);
                T_LSR, T_ASR: dec_cnt = (amt[4:0] == 5'd0) ? CNT_W'(32) : CNT_W'(amt[4:0]);
                default: begin
                    if (amt[4:0] == 5'd0) begin
                        dec_rrx = 1'b1;
                        dec_cnt = CNT_W'(1);
                    end else begin
                        dec_cnt = CNT_W'(amt[4:0]);
                    end
                end
            endcase
        end else if (amt != '0) begin
            case (bus.SH_TYPE)
                T_LSL, T_LSR: dec_cnt = (amt > AMT_W'(33)) ? CNT_W'(33) : CNT_W'(amt);
                T_ASR: dec_cnt = (amt > AMT_W'(32)) ? CNT_W'(32) : CNT_W'(amt);
                default: begin
                    dec_cnt = CNT_W'(amt[4:0]);
                    // A rotate by a non-zero multiple of 32 leaves RM intact but carries out bit 31
                    if (amt[4:0] == 5'd0) dec_c = bus.RM[WIDTH-1];
                end
            endcase
        end
    end

`ifdef SHIFTER_BARREL_EN
    logic [WIDTH:0]   bar;
    logic [WIDTH-1:0] res_l;
    logic             resc_l;

    // Full shift in one pass; returns {carry, result}
    function automatic logic [WIDTH:0] barrel_shift(
        input logic [WIDTH-1:0] w,
        input logic             c,
        input logic [1:0]       t,
        input logic             rrx,
        input logic [CNT_W-1:0] n
    );
        logic [WIDTH:0]        up;
        logic [WIDTH:0]        dn;
        logic signed [WIDTH:0] sdn;
        logic [WIDTH-1:0]      rot;
        logic [WIDTH:0]        r;
        up  = {1'b0, w} << n;
        dn  = {w, 1'b0} >> n;
        sdn = $signed({w, 1'b0}) >>> n;
        rot = (w >> n) | (w << (CNT_W'(WIDTH) - n));
        if (rrx) begin
            r = {w[0], c, w[WIDTH-1:1]};
        end else if (n == '0) begin
            r = {c, w};
        end else begin
            case (t)
                T_LSL:   r = up;
                T_LSR:   r = {dn[0], dn[WIDTH:1]};
                T_ASR:   r = {sdn[0], sdn[WIDTH:1]};
                default: r = {rot[WIDTH-1], rot};
            endcase
        end
        return r;
    endfunction

    assign bar = barrel_shift(bus.RM, dec_c, bus.SH_TYPE, dec_rrx, dec_cnt);

    // Control: one evaluation cycle, then the one-cycle FIN that publishes the result
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= S_IDLE;
            b_out_r <= '0;
            sh_c_r  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.START) state <= S_EVAL;
                S_EVAL: begin
                    state   <= S_FIN;
                    b_out_r <= res_l;
                    sh_c_r  <= resc_l;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Capture the barrel result at START so later input changes are irrelevant
    always_ff @(posedge CLK) begin
        if (state == S_IDLE && bus.START) begin
            res_l  <= bar[WIDTH-1:0];
            resc_l <= bar[WIDTH];
        end
    end

    assign bus.BUSY = 1'b0;
`else
    logic [CNT_W-1:0]        cnt;
    logic [WIDTH-1:0]        work;
    logic signed [WIDTH-1:0] work_s;
    logic                    wc;
    logic [1:0]              typ_l;
    logic                    rrx_l;
    logic [WIDTH-1:0]        step_w;
    logic                    step_c;

    assign work_s = work;

    // One-bit step of the latched operation; carry takes the bit shifted out
    always_comb begin
        step_w = work;
        step_c = wc;
        if (rrx_l) begin
            step_w = {wc, work[WIDTH-1:1]};
            step_c = work[0];
        end else begin
            case (typ_l)
                T_LSL: {step_c, step_w} = {work, 1'b0};
                T_LSR: begin
                    step_w = {1'b0, work[WIDTH-1:1]};
                    step_c = work[0];
                end
                T_ASR: begin
                    step_w = work_s >>> 1;
                    step_c = work[0];
                end
                default: begin
                    step_w = {work[0], work[WIDTH-1:1]};
                    step_c = work[0];
                end
            endcase
        end
    end

    // Control: count down the decoded steps, then publish the result in FIN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= S_IDLE;
            cnt     <= '0;
            b_out_r <= '0;
            sh_c_r  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.START) begin
                        state <= S_SHIFT;
                        cnt   <= dec_cnt;
                    end
                end
                S_SHIFT: begin
                    if (cnt == '0) begin
                        state   <= S_FIN;
                        b_out_r <= work;
                        sh_c_r  <= wc;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Working operand: loaded at START, stepped once per remaining count
    always_ff @(posedge CLK) begin
        if (state == S_IDLE && bus.START) begin
            work  <= bus.RM;
            wc    <= dec_c;
            typ_l <= bus.SH_TYPE;
            rrx_l <= dec_rrx;
        end else if (state == S_SHIFT && cnt != '0) begin
            work <= step_w;
            wc   <= step_c;
        end
    end

    assign bus.BUSY = (state == S_SHIFT);
`endif

    assign bus.DONE  = (state == S_FIN);
    assign bus.B_OUT = b_out_r;
    assign bus.SH_C  = sh_c_r;
endmodule

// File: tb/tb_shifter_operand_unit.sv
// Directed and randomized bench for shifter_operand_unit (either SHIFTER_BARREL_EN build).
module tb_shifter_operand_unit;
    localparam logic [1:0] T_LSL = 2'b00;
    localparam logic [1:0] T_LSR = 2'b01;
    localparam logic [1:0] T_ASR = 2'b10;
    localparam logic [1:0] T_ROR = 2'b11;
`ifdef SHIFTER_BARREL_EN
    localparam bit BARREL = 1'b1;
    localparam int RST_EDGES = 0;
`else
    localparam bit BARREL = 1'b0;
    localparam int RST_EDGES = 3;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int pass_cnt = 0;
    int total_cnt = 0;
    int done_pulses = 0;

    shifter_operand_unit_if #(.WIDTH(32), .AMT_W(8)) bus ();

    shifter_operand_unit #(.WIDTH(32), .AMT_W(8), .CNT_W(6)) dut (
        .CLK(clk),
        .RESET_N(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.DONE) done_pulses <= done_pulses + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // ARM shifter semantics; returns {carry, result}
    function automatic logic [32:0] ref_shift(input logic rs, input logic [1:0] t,
                                              input logic [7:0] amt, input logic [31:0] rm,
                                              input logic cin);
        int s;
        int s5;
        logic [31:0] r;
        logic c;
        s = rs ? int'(amt) : int'(amt[4:0]);
        if (!rs && s == 0) begin
            if (t == T_ROR) return {rm[0], cin, rm[31:1]};
            if (t != T_LSL) s = 32;
        end
        if (s == 0) return {cin, rm};
        case (t)
            T_LSL: begin
                if (s < 32) begin r = rm << s; c = rm[32 - s]; end
                else begin r = '0; c = (s == 32) ? rm[0] : 1'b0; end
            end
            T_LSR: begin
                if (s < 32) begin r = rm >> s; c = rm[s - 1]; end
                else begin r = '0; c = (s == 32) ? rm[31] : 1'b0; end
            end
            T_ASR: begin
                if (s < 32) begin r = $signed(rm) >>> s; c = rm[s - 1]; end
                else begin r = {32{rm[31]}}; c = rm[31]; end
            end
            default: begin
                s5 = s % 32;
                if (s5 == 0) begin r = rm; c = rm[31]; end
                else begin r = (rm >> s5) | (rm << (32 - s5)); c = rm[s5 - 1]; end
            end
        endcase
        return {c, r};
    endfunction

    // Cycles from the START edge to the DONE edge
    function automatic int ref_lat(input logic rs, input logic [1:0] t, input logic [7:0] amt);
        int n;
        if (!rs) begin
            if (amt[4:0] == 5'd0) n = (t == T_LSL) ? 0 : (t == T_ROR) ? 1 : 32;
            else n = int'(amt[4:0]);
        end else if (amt == 8'd0) begin
            n = 0;
        end else if (t == T_ROR) begin
            n = int'(amt) % 32;
        end else begin
            n = int'(amt);
            if (t == T_ASR && n > 32) n = 32;
            if (n > 33) n = 33;
        end
        if (BARREL) n = 0;
        return n + 1;
    endfunction

    function automatic int lat_of(input int n);
        return BARREL ? 1 : n;
    endfunction

    task automatic scramble();
        bus.REG_SHIFT = 1'($urandom);
        bus.SH_TYPE   = 2'($urandom);
        bus.SH_AMT    = 8'($urandom);
        bus.RM        = $urandom;
        bus.CIN       = 1'($urandom);
    endtask

    task automatic run_op(input string tag, input logic rs, input logic [1:0] t,
                          input logic [7:0] amt, input logic [31:0] rm, input logic cin,
                          input logic [31:0] exp_b, input logic exp_c, input int exp_lat);
        int lat;
        bit seen;
        @(negedge clk);
        bus.START = 1'b1; bus.REG_SHIFT = rs; bus.SH_TYPE = t;
        bus.SH_AMT = amt; bus.RM = rm; bus.CIN = cin;
        @(posedge clk); #1;
        bus.START = 1'b0;
        scramble();
        check({tag, " busy"}, {31'b0, bus.BUSY}, BARREL ? 32'd0 : 32'd1);
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            seen = bus.DONE;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " b_out"}, bus.B_OUT, exp_b);
        check({tag, " sh_c"}, {31'b0, bus.SH_C}, {31'b0, exp_c});
        @(posedge clk); #1;
        check({tag, " done_pulse"}, {31'b0, bus.DONE}, 32'd0);
    endtask

    initial begin
        int dp0;
        logic [32:0] e;
        logic rs;
        logic [1:0] t;
        logic [7:0] amt;
        logic [31:0] rm;
        logic cin;
        int sel;

        bus.START = 1'b0; bus.REG_SHIFT = 1'b0; bus.SH_TYPE = 2'b00;
        bus.SH_AMT = 8'd0; bus.RM = '0; bus.CIN = 1'b0;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst b_out", bus.B_OUT, 32'd0);
        check("rst sh_c", {31'b0, bus.SH_C}, 32'd0);
        check("rst busy", {31'b0, bus.BUSY}, 32'd0);
        check("rst done", {31'b0, bus.DONE}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        run_op("t1 lsl4", 1'b0, T_LSL, 8'd4, 32'h12344567, 1'b0, 32'h23445670, 1'b1, lat_of(5));
        run_op("t2 lsr0", 1'b0, T_LSR, 8'd0, 32'hF000FE18, 1'b0, 32'h00000000, 1'b1, lat_of(33));
        run_op("t2 lsl33", 1'b1, T_LSL, 8'd33, 32'h50000000, 1'b1, 32'h00000000, 1'b0, lat_of(34));
        run_op("t3 asr40", 1'b1, T_ASR, 8'd40, 32'hB0000000, 1'b0, 32'hFFFFFFFF, 1'b1, lat_of(33));
        run_op("t3 ror32", 1'b1, T_ROR, 8'd32, 32'h80000001, 1'b0, 32'h80000001, 1'b1, lat_of(1));
        run_op("t4 rrx", 1'b0, T_ROR, 8'd0, 32'h00000001, 1'b1, 32'h80000000, 1'b1, lat_of(2));

        // Test 5: amount 0, with START held high through the busy/FIN cycles
        @(negedge clk);
        bus.START = 1'b1; bus.REG_SHIFT = 1'b1; bus.SH_TYPE = T_LSR;
        bus.SH_AMT = 8'd0; bus.RM = 32'h0DAE2310; bus.CIN = 1'b1;
        @(posedge clk); #1;
        dp0 = done_pulses;
        bus.REG_SHIFT = 1'b0; bus.SH_TYPE = T_LSL; bus.SH_AMT = 8'd1;
        bus.RM = 32'h00000001; bus.CIN = 1'b0;
        @(posedge clk); #1;
        check("t5 done k+1", {31'b0, bus.DONE}, 32'd1);
        check("t5 b_out", bus.B_OUT, 32'h0DAE2310);
        check("t5 sh_c", {31'b0, bus.SH_C}, 32'd1);
        @(posedge clk); #1;
        bus.START = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("t5 one done", 32'(done_pulses - dp0), 32'd1);
        check("t5 kept b_out", bus.B_OUT, 32'h0DAE2310);
        check("t5 kept sh_c", {31'b0, bus.SH_C}, 32'd1);

        // Test 6: asynchronous reset in the middle of an operation
        @(negedge clk);
        bus.START = 1'b1; bus.REG_SHIFT = 1'b1; bus.SH_TYPE = T_LSR;
        bus.SH_AMT = 8'd16; bus.RM = 32'hA5A5F00F; bus.CIN = 1'b0;
        @(posedge clk); #1;
        bus.START = 1'b0;
        dp0 = done_pulses;
        repeat (RST_EDGES) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6 rst b_out", bus.B_OUT, 32'd0);
        check("t6 rst sh_c", {31'b0, bus.SH_C}, 32'd0);
        check("t6 rst busy", {31'b0, bus.BUSY}, 32'd0);
        check("t6 rst done", {31'b0, bus.DONE}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("t6 no done", 32'(done_pulses - dp0), 32'd0);
        run_op("t6 lsl1", 1'b0, T_LSL, 8'd1, 32'h00000003, 1'b0, 32'h00000006, 1'b0, lat_of(2));

        // Random sweep against the ARM shift model, back to back
        for (int i = 0; i < 80; i++) begin
            rs  = 1'($urandom);
            t   = 2'($urandom);
            sel = int'($urandom_range(0, 3));
            case (sel)
                0: amt = 8'($urandom_range(0, 40));
                1: amt = 8'($urandom);
                2: amt = (($urandom & 1) != 0) ? 8'd32 : 8'd0;
                default: amt = 8'($urandom_range(0, 31));
            endcase
            rm  = $urandom;
            cin = 1'($urandom);
            e = ref_shift(rs, t, amt, rm, cin);
            run_op($sformatf("rnd%0d rs%0d t%0d a%0d", i, rs, t, amt), rs, t, amt, rm, cin,
                   e[31:0], e[32], ref_lat(rs, t, amt));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
